// File: rtl/execute_unit_if.sv
// Execute-stage bus: decode-side operands/control, forwarding sources, and the
// E-stage bundle returned to the memory stage and hazard unit.
//   slave  : used by execute_unit (consumes D inputs, drives E outputs)
//   master : used by the driver of the decode side (testbench / pipeline top)
interface execute_unit_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned REG_W = 5;

  // decode-side inputs
  logic [WIDTH-1:0] EU_RD1D;
  logic [WIDTH-1:0] EU_RD2D;
  logic [REG_W-1:0] EU_RsD;
  logic [REG_W-1:0] EU_RtD;
  logic [REG_W-1:0] EU_RdD;
  logic [WIDTH-1:0] EU_SignImmD;
  logic             EU_RegWriteD;
  logic             EU_MemWriteD;
  logic             EU_MemToRegD;
  logic             EU_ALUSrcD;
  logic             EU_RegDstD;
  logic [2:0]       EU_ALUControlD;
  logic [2:0]       EU_MDOpD;
  logic             EU_FlushE;
  logic [1:0]       EU_ForwardAE;
  logic [1:0]       EU_ForwardBE;
  logic [WIDTH-1:0] EU_ResultW;
  logic [WIDTH-1:0] EU_AluOutM;

  // execute-stage outputs
  logic [WIDTH-1:0] EU_AluOutE;
  logic [WIDTH-1:0] EU_WriteDataE;
  logic [REG_W-1:0] EU_WriteRegE;
  logic             EU_RegWriteE;
  logic             EU_MemWriteE;
  logic             EU_MemToRegE;
  logic [REG_W-1:0] EU_RsE;
  logic [REG_W-1:0] EU_RtE;
  logic             EU_StallE;

  modport slave (
    input  EU_RD1D, EU_RD2D, EU_RsD, EU_RtD, EU_RdD, EU_SignImmD,
           EU_RegWriteD, EU_MemWriteD, EU_MemToRegD, EU_ALUSrcD, EU_RegDstD,
           EU_ALUControlD, EU_MDOpD, EU_FlushE, EU_ForwardAE, EU_ForwardBE,
           EU_ResultW, EU_AluOutM,
    output EU_AluOutE, EU_WriteDataE, EU_WriteRegE, EU_RegWriteE,
           EU_MemWriteE, EU_MemToRegE, EU_RsE, EU_RtE, EU_StallE
  );

  modport master (
    output EU_RD1D, EU_RD2D, EU_RsD, EU_RtD, EU_RdD, EU_SignImmD,
           EU_RegWriteD, EU_MemWriteD, EU_MemToRegD, EU_ALUSrcD, EU_RegDstD,
           EU_ALUControlD, EU_MDOpD, EU_FlushE, EU_ForwardAE, EU_ForwardBE,
           EU_ResultW, EU_AluOutM,
    input  EU_AluOutE, EU_WriteDataE, EU_WriteRegE, EU_RegWriteE,
           EU_MemWriteE, EU_MemToRegE, EU_RsE, EU_RtE, EU_StallE
  );
endinterface

// File: rtl/execute_unit.sv
// Execute stage of the pipelined MIPS core: D->E pipeline register,
// operand forwarding, ALU, and an iterative unsigned MULTU/DIVU engine
// with HI/LO registers that stalls dependent mul/div instructions.
// Ports:
//   EU_CLK  : clock, rising edge
//   EU_RST  : asynchronous active-low reset
//   bus     : execute_unit_if.slave (decode inputs, forwarding, E outputs)
// Build option: define EXECUTE_MULDIV_EN to include the mul/div engine and
// HI/LO; without it MULTU/DIVU are nops, MFHI/MFLO read 0, EU_StallE is 0.
module execute_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          EU_CLK,
  input  logic          EU_RST,
  execute_unit_if.slave bus
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned MD_W   = 3;

  localparam logic [MD_W-1:0] MD_NONE  = 3'b000;
  localparam logic [MD_W-1:0] MD_MULTU = 3'b001;
  localparam logic [MD_W-1:0] MD_DIVU  = 3'b010;
  localparam logic [MD_W-1:0] MD_MFHI  = 3'b011;
  localparam logic [MD_W-1:0] MD_MFLO  = 3'b100;

  localparam logic [CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [WIDTH-1:0]  imm;
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic              reg_dst;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [MD_W-1:0]   md_op;
  } de_reg_t;

  de_reg_t          de_d;
  de_reg_t          de_q;
  logic             stall;
  logic             md_arith;
  logic             slt_lt;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b_fwd;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] hi_val;
  logic [WIDTH-1:0] lo_val;

  // Forwarding source select: 01 writeback, 10 memory, else register file.
  function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0]       sel,
                                               input logic [WIDTH-1:0] rf,
                                               input logic [WIDTH-1:0] w,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] y;
    case (sel)
      2'b01:   y = w;
      2'b10:   y = m;
      default: y = rf;
    endcase
    return y;
  endfunction

  // Gather decode inputs into the pipeline-register payload.
  always_comb begin
    de_d            = '0;
    de_d.rd1        = bus.EU_RD1D;
    de_d.rd2        = bus.EU_RD2D;
    de_d.rs         = bus.EU_RsD;
    de_d.rt         = bus.EU_RtD;
    de_d.rd         = bus.EU_RdD;
    de_d.imm        = bus.EU_SignImmD;
    de_d.reg_write  = bus.EU_RegWriteD;
    de_d.mem_write  = bus.EU_MemWriteD;
    de_d.mem_to_reg = bus.EU_MemToRegD;
    de_d.alu_src    = bus.EU_ALUSrcD;
    de_d.reg_dst    = bus.EU_RegDstD;
    de_d.alu_ctrl   = bus.EU_ALUControlD;
    de_d.md_op      = bus.EU_MDOpD;
  end

  // D->E register; a stall holds the instruction even when a flush is requested.
  always_ff @(posedge EU_CLK or negedge EU_RST) begin
    if (!EU_RST) begin
      de_q <= '0;
    end else if (!stall) begin
      if (bus.EU_FlushE) de_q <= '0;
      else               de_q <= de_d;
    end
  end

  // Operand forwarding and ALU.
  always_comb begin
    src_a     = fwd_sel(bus.EU_ForwardAE, de_q.rd1, bus.EU_ResultW, bus.EU_AluOutM);
    src_b_fwd = fwd_sel(bus.EU_ForwardBE, de_q.rd2, bus.EU_ResultW, bus.EU_AluOutM);
    alu_b     = de_q.alu_src ? de_q.imm : src_b_fwd;
    slt_lt    = $signed(src_a) < $signed(alu_b);
    alu_y     = '0;
    case (de_q.alu_ctrl)
      ALU_ADD: alu_y = src_a + alu_b;
      ALU_SUB: alu_y = src_a - alu_b;
      ALU_AND: alu_y = src_a & alu_b;
      ALU_OR:  alu_y = src_a | alu_b;
      ALU_SLT: alu_y = WIDTH'(slt_lt);
      default: alu_y = '0;
    endcase
  end

  assign md_arith = (de_q.md_op == MD_MULTU) || (de_q.md_op == MD_DIVU);

`ifdef EXECUTE_MULDIV_EN
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } md_state_t;

  md_state_t        state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_n;
  logic [WIDTH-1:0] div_quo_n;
  logic             last_iter;

  // One iteration of each algorithm. Multiply: {work_hi,work_lo} is the
  // partial product with the multiplier shifting out of work_lo. Divide:
  // work_hi is the remainder, work_lo shifts dividend bits out and quotient
  // bits in. A zero divisor always "fits", giving LO=all ones and HI=A.
  always_comb begin
    mul_sum              = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_a} : '0);
    {mul_hi_n, mul_lo_n} = {mul_sum, work_lo[WIDTH-1:1]};
    div_shift            = {work_hi, work_lo[WIDTH-1]};
    div_diff             = div_shift - {1'b0, op_b};
    div_ge               = div_shift >= {1'b0, op_b};
    div_rem_n            = div_ge ? WIDTH'(div_diff) : WIDTH'(div_shift);
    div_quo_n            = {work_lo[WIDTH-2:0], div_ge};
    last_iter            = (count == CNT_W'(WIDTH - 1));
  end

  // Engine FSM: loads from the forwarded operands, then one iteration per edge.
  always_ff @(posedge EU_CLK or negedge EU_RST) begin
    if (!EU_RST) begin
      state   <= S_IDLE;
      count   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_a    <= '0;
      op_b    <= '0;
      work_hi <= '0;
      work_lo <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_arith && !stall) begin
            op_a    <= src_a;
            op_b    <= src_b_fwd;
            count   <= '0;
            work_hi <= '0;
            if (de_q.md_op == MD_MULTU) begin
              work_lo <= src_b_fwd;
              state   <= S_MUL;
            end else begin
              work_lo <= src_a;
              state   <= S_DIV;
            end
          end
        end
        S_MUL: begin
          work_hi <= mul_hi_n;
          work_lo <= mul_lo_n;
          count   <= count + CNT_W'(1);
          if (last_iter) begin
            hi_q  <= mul_hi_n;
            lo_q  <= mul_lo_n;
            state <= S_IDLE;
          end
        end
        S_DIV: begin
          work_hi <= div_rem_n;
          work_lo <= div_quo_n;
          count   <= count + CNT_W'(1);
          if (last_iter) begin
            hi_q  <= div_rem_n;
            lo_q  <= div_quo_n;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall  = (state != S_IDLE) && (de_q.md_op != MD_NONE);
  assign hi_val = hi_q;
  assign lo_val = lo_q;
`else
  assign stall  = 1'b0;
  assign hi_val = '0;
  assign lo_val = '0;
`endif

  // E-stage bundle; stalled or mul/div-issue cycles send a bubble to M.
  assign bus.EU_AluOutE    = (de_q.md_op == MD_MFHI) ? hi_val :
                             (de_q.md_op == MD_MFLO) ? lo_val : alu_y;
  assign bus.EU_WriteDataE = src_b_fwd;
  assign bus.EU_WriteRegE  = de_q.reg_dst ? de_q.rd : de_q.rt;
  assign bus.EU_RegWriteE  = de_q.reg_write && !stall && !md_arith;
  assign bus.EU_MemWriteE  = de_q.mem_write && !stall && !md_arith;
  assign bus.EU_MemToRegE  = de_q.mem_to_reg;
  assign bus.EU_RsE        = de_q.rs;
  assign bus.EU_RtE        = de_q.rt;
  assign bus.EU_StallE     = stall;
endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed ALU/forwarding vector table,
// hand sequences for mul/div, flush, and reset corners, then random traffic,
// all compared against a cycle-level reference model of the execute stage.
module tb_execute_unit;
  localparam int unsigned W = 32;
`ifdef EXECUTE_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [4:0]   rd;
    logic [W-1:0] imm;
    logic         rw;
    logic         mw;
    logic         mtr;
    logic         alu_src;
    logic         reg_dst;
    logic [2:0]   ctrl;
    logic [2:0]   md;
  } dvec_t;

  typedef struct {
    logic [W-1:0] rd1;
    logic [W-1:0] rd2;
    logic [W-1:0] imm;
    logic         alu_src;
    logic [2:0]   ctrl;
    logic [1:0]   fa;
    logic [1:0]   fb;
    logic [W-1:0] alu_m;
    logic [W-1:0] res_w;
    logic [W-1:0] exp_alu;
    logic [W-1:0] exp_wd;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  execute_unit_if #(.WIDTH(W)) bus ();
  execute_unit #(.WIDTH(W)) dut (.EU_CLK(clk), .EU_RST(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  dvec_t          m_e;
  logic [W-1:0]   m_hi, m_lo;
  logic [2*W-1:0] m_res;
  bit             m_pending;
  int             m_left;
  // model outputs for the current cycle
  logic [W-1:0]   e_alu, e_wd, e_a, e_bw;
  logic [4:0]     e_wr;
  logic           e_rw, e_mw, e_mtr, e_st;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] fwd(input logic [1:0] s, input logic [W-1:0] rf);
    if (s == 2'b01) return bus.EU_ResultW;
    if (s == 2'b10) return bus.EU_AluOutM;
    return rf;
  endfunction

  task automatic model_eval();
    logic [W-1:0] b, alu;
    bit arith;
    e_a  = fwd(bus.EU_ForwardAE, m_e.rd1);
    e_bw = fwd(bus.EU_ForwardBE, m_e.rd2);
    b    = m_e.alu_src ? m_e.imm : e_bw;
    case (m_e.ctrl)
      3'b010:  alu = e_a + b;
      3'b110:  alu = e_a - b;
      3'b000:  alu = e_a & b;
      3'b001:  alu = e_a | b;
      3'b111:  alu = ($signed(e_a) < $signed(b)) ? 32'd1 : 32'd0;
      default: alu = 32'd0;
    endcase
    arith = (m_e.md == 3'd1) || (m_e.md == 3'd2);
    e_st  = MD_EN && m_pending && (m_e.md != 3'd0);
    e_alu = (m_e.md == 3'd3) ? m_hi : (m_e.md == 3'd4) ? m_lo : alu;
    e_wd  = e_bw;
    e_wr  = m_e.reg_dst ? m_e.rd : m_e.rt;
    e_rw  = m_e.rw && !e_st && !arith;
    e_mw  = m_e.mw && !e_st && !arith;
    e_mtr = m_e.mtr;
  endtask

  function automatic dvec_t capture();
    dvec_t v;
    v.rd1 = bus.EU_RD1D;          v.rd2 = bus.EU_RD2D;
    v.rs = bus.EU_RsD;            v.rt = bus.EU_RtD;          v.rd = bus.EU_RdD;
    v.imm = bus.EU_SignImmD;      v.rw = bus.EU_RegWriteD;    v.mw = bus.EU_MemWriteD;
    v.mtr = bus.EU_MemToRegD;     v.alu_src = bus.EU_ALUSrcD; v.reg_dst = bus.EU_RegDstD;
    v.ctrl = bus.EU_ALUControlD;  v.md = bus.EU_MDOpD;
    return v;
  endfunction

  // Advance the model across one rising edge using the pre-edge inputs.
  task automatic model_edge();
    model_eval();
    if (m_pending) begin
      m_left--;
      if (m_left == 0) begin
        {m_hi, m_lo} = m_res;
        m_pending    = 1'b0;
      end
    end else if (MD_EN && (m_e.md == 3'd1 || m_e.md == 3'd2)) begin
      m_pending = 1'b1;
      m_left    = 32;
      if (m_e.md == 3'd1)  m_res = 64'(e_a) * 64'(e_bw);
      else if (e_bw == 0)  m_res = {e_a, 32'hFFFF_FFFF};
      else                 m_res = {e_a % e_bw, e_a / e_bw};
    end
    if (!e_st) m_e = bus.EU_FlushE ? dvec_t'('0) : capture();
  endtask

  task automatic model_reset();
    m_e = '0; m_hi = '0; m_lo = '0; m_res = '0; m_pending = 1'b0; m_left = 0;
  endtask

  task automatic check_model();
    model_eval();
    chk("alu_out",   bus.EU_AluOutE, e_alu);
    chk("wdata",     bus.EU_WriteDataE, e_wd);
    chk("write_reg", 32'(bus.EU_WriteRegE), 32'(e_wr));
    chk("reg_write", 32'(bus.EU_RegWriteE), 32'(e_rw));
    chk("mem_write", 32'(bus.EU_MemWriteE), 32'(e_mw));
    chk("mem2reg",   32'(bus.EU_MemToRegE), 32'(e_mtr));
    chk("rs_e",      32'(bus.EU_RsE), 32'(m_e.rs));
    chk("rt_e",      32'(bus.EU_RtE), 32'(m_e.rt));
    chk("stall",     32'(bus.EU_StallE), 32'(e_st));
  endtask

  // Check the current cycle, then cross one rising edge.
  task automatic step();
    #1;
    check_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input dvec_t v);
    bus.EU_RD1D = v.rd1;          bus.EU_RD2D = v.rd2;
    bus.EU_RsD = v.rs;            bus.EU_RtD = v.rt;          bus.EU_RdD = v.rd;
    bus.EU_SignImmD = v.imm;      bus.EU_RegWriteD = v.rw;    bus.EU_MemWriteD = v.mw;
    bus.EU_MemToRegD = v.mtr;     bus.EU_ALUSrcD = v.alu_src; bus.EU_RegDstD = v.reg_dst;
    bus.EU_ALUControlD = v.ctrl;  bus.EU_MDOpD = v.md;
  endtask

  task automatic set_fwd(input logic [1:0] fa, input logic [1:0] fb,
                         input logic [W-1:0] res_w, input logic [W-1:0] alu_m);
    bus.EU_ForwardAE = fa; bus.EU_ForwardBE = fb;
    bus.EU_ResultW = res_w; bus.EU_AluOutM = alu_m;
  endtask

  function automatic dvec_t md_d(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [4:0] rs);
    dvec_t v = '0;
    v.rd1 = a; v.rd2 = b; v.md = op; v.rw = 1'b1; v.reg_dst = 1'b1;
    v.rd = 5'd2; v.rt = 5'd3; v.rs = rs; v.ctrl = 3'b010;
    return v;
  endfunction

  // Count stalled cycles, bounded so a stuck stall cannot hang the run.
  task automatic wait_stall(output int n);
    n = 0;
    #1;
    while (bus.EU_StallE === 1'b1 && n < 40) begin
      n++;
      step();
      #1;
    end
  endtask

  // Issue a mul/div op, then two HI/LO reads; the first read waits on the engine.
  task automatic md_seq(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] r1, input logic [2:0] r2,
                        input logic [W-1:0] exp1, input logic [W-1:0] exp2);
    int n;
    set_fwd(2'b00, 2'b00, '0, '0);
    bus.EU_FlushE = 1'b0;
    set_d(md_d(op, a, b, 5'd4)); step();
    set_d(md_d(r1, '0, '0, 5'd4)); step();
    set_d(md_d(r2, '0, '0, 5'd4));
    wait_stall(n);
    chk({tag, "_stall_len"}, 32'(n), MD_EN ? 32'd32 : 32'd0);
    chk({tag, "_read1"}, bus.EU_AluOutE, exp1);
    chk({tag, "_read1_rw"}, 32'(bus.EU_RegWriteE), 32'd1);
    step();
    set_d('0);
    #1;
    chk({tag, "_read2"}, bus.EU_AluOutE, exp2);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("rst_stall", 32'(bus.EU_StallE), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    dvec_t v;
    vecs[0] = '{32'd5, 32'd7, 32'd0, 1'b0, 3'b010, 2'b00, 2'b00, 32'd0, 32'd0, 32'd12, 32'd7};
    vecs[1] = '{32'd1, 32'h55, 32'h10, 1'b1, 3'b110, 2'b10, 2'b00, 32'h100, 32'd0, 32'hF0, 32'h55};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b111, 2'b00, 2'b00, 32'd0, 32'd0, 32'd1, 32'd1};
    vecs[3] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b010, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd1};
    vecs[4] = '{32'hFF00, 32'd0, 32'd0, 1'b0, 3'b000, 2'b00, 2'b01, 32'd0, 32'hF0F0, 32'hF000, 32'hF0F0};
    vecs[5] = '{32'h0F, 32'd3, 32'hF0, 1'b1, 3'b001, 2'b00, 2'b00, 32'd0, 32'd0, 32'hFF, 32'd3};
    vecs[6] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 3'b111, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
    vecs[7] = '{32'd5, 32'd6, 32'd0, 1'b0, 3'b011, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd6};
    vecs[8] = '{32'd3, 32'd4, 32'd0, 1'b0, 3'b010, 2'b11, 2'b11, 32'h999, 32'h888, 32'd7, 32'd4};
    vecs[9] = '{32'd0, 32'd1, 32'd0, 1'b0, 3'b110, 2'b00, 2'b00, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1};

    model_reset();
    set_d('0);
    set_fwd(2'b00, 2'b00, '0, '0);
    bus.EU_FlushE = 1'b0;
    #12;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // ALU / forwarding vector table
    foreach (vecs[i]) begin
      v = '0;
      v.rd1 = vecs[i].rd1; v.rd2 = vecs[i].rd2; v.imm = vecs[i].imm;
      v.alu_src = vecs[i].alu_src; v.ctrl = vecs[i].ctrl; v.rw = 1'b1; v.rt = 5'(i);
      set_d(v);
      set_fwd(2'b00, 2'b00, '0, '0);
      step();
      set_fwd(vecs[i].fa, vecs[i].fb, vecs[i].res_w, vecs[i].alu_m);
      #1;
      chk($sformatf("vec%0d_alu", i), bus.EU_AluOutE, vecs[i].exp_alu);
      chk($sformatf("vec%0d_wdata", i), bus.EU_WriteDataE, vecs[i].exp_wd);
    end
    set_d('0);
    set_fwd(2'b00, 2'b00, '0, '0);
    step();

    // mul/div through HI/LO
    md_seq("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3, 3'd4,
           MD_EN ? 32'hFFFF_FFFE : 32'd0, MD_EN ? 32'd1 : 32'd0);
    md_seq("divu_100_7", 3'd2, 32'd100, 32'd7, 3'd4, 3'd3,
           MD_EN ? 32'd14 : 32'd0, MD_EN ? 32'd2 : 32'd0);
    md_seq("divu_9_0", 3'd2, 32'd9, 32'd0, 3'd4, 3'd3,
           MD_EN ? 32'hFFFF_FFFF : 32'd0, MD_EN ? 32'd9 : 32'd0);

    // flush while stalled must not disturb the held MFLO
    set_d(md_d(3'd1, 32'd3, 32'd4, 5'd4)); step();
    set_d(md_d(3'd4, '0, '0, 5'd7)); step();
    set_d('0);
    bus.EU_FlushE = 1'b1;
    step();
    bus.EU_FlushE = 1'b0;
    #1;
    chk("flush_stall_rs", 32'(bus.EU_RsE), MD_EN ? 32'd7 : 32'd0);
    chk("flush_stall_st", 32'(bus.EU_StallE), MD_EN ? 32'd1 : 32'd0);
    wait_stall(n);
    chk("flush_stall_lo", bus.EU_AluOutE, MD_EN ? 32'd12 : 32'd0);
    step();

    // flush while idle gives a bubble
    v = '0; v.rd1 = 32'd5; v.rd2 = 32'd7; v.ctrl = 3'b010; v.rw = 1'b1; v.mw = 1'b1; v.rs = 5'd9;
    set_d(v);
    bus.EU_FlushE = 1'b1;
    step();
    bus.EU_FlushE = 1'b0;
    set_d('0);
    #1;
    chk("flush_idle_alu", bus.EU_AluOutE, 32'd0);
    chk("flush_idle_rw", 32'(bus.EU_RegWriteE), 32'd0);
    chk("flush_idle_rs", 32'(bus.EU_RsE), 32'd0);
    step();

    // reset during busy cycle 10 discards the operation
    set_d(md_d(3'd1, 32'hFFFF, 32'h10001, 5'd4)); step();
    set_d(md_d(3'd3, '0, '0, 5'd4)); step();
    repeat (9) step();
    #1;
    chk("busy10_stall", 32'(bus.EU_StallE), MD_EN ? 32'd1 : 32'd0);
    do_reset();
    set_d(md_d(3'd3, '0, '0, 5'd4)); step();
    set_d('0);
    #1;
    chk("hi_after_rst", bus.EU_AluOutE, 32'd0);
    step();

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      int r;
      v.rd1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      v.rd2 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      v.imm = $urandom;
      v.rs = 5'($urandom); v.rt = 5'($urandom); v.rd = 5'($urandom);
      v.rw = 1'($urandom); v.mw = 1'($urandom); v.mtr = 1'($urandom);
      v.alu_src = 1'($urandom); v.reg_dst = 1'($urandom);
      case ($urandom_range(0, 5))
        0: v.ctrl = 3'b000;
        1: v.ctrl = 3'b001;
        2: v.ctrl = 3'b010;
        3: v.ctrl = 3'b110;
        4: v.ctrl = 3'b111;
        default: v.ctrl = 3'b011;
      endcase
      r = $urandom_range(0, 15);
      v.md = (r < 5) ? 3'(r) : 3'd0;
      set_d(v);
      set_fwd(2'($urandom), 2'($urandom), $urandom, $urandom);
      bus.EU_FlushE = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage of the pipelined MIPS core: registers decode-stage operands and control (D→E pipeline register), applies forwarding, runs the ALU and produces the E-stage bundle (ALU result, store data, destination register, RegWrite/MemWrite/MemToReg) that the memory stage registers next. It also owns an iterative unsigned multiply/divide engine with HI/LO registers, and requests a pipeline stall while a dependent instruction waits on that engine.

## Interface
- WIDTH, 32, datapath width.
- EU_CLK  in  1  clock; all state updates on the rising edge.
- EU_RST  in  1  asynchronous, active-low reset.
- EU_RD1D, EU_RD2D  in  WIDTH  register-file read data from decode.
- EU_RsD, EU_RtD, EU_RdD  in  5  register specifiers.
- EU_SignImmD  in  WIDTH  sign-extended immediate.
- EU_RegWriteD, EU_MemWriteD, EU_MemToRegD, EU_ALUSrcD, EU_RegDstD  in  1  decode control.
- EU_ALUControlD  in  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- EU_MDOpD  in  3  000 none, 001 MULTU, 010 DIVU, 011 MFHI, 100 MFLO.
- EU_FlushE  in  1  load D→E register with a bubble (all fields zero).
- EU_ForwardAE, EU_ForwardBE  in  2  00 register file, 01 EU_ResultW, 10 EU_AluOutM, 11 register file.
- EU_ResultW, EU_AluOutM  in  WIDTH  forwarding sources.
- EU_AluOutE, EU_WriteDataE  out  WIDTH  result, store data (to memory stage).
- EU_WriteRegE  out  5; EU_RegWriteE, EU_MemWriteE, EU_MemToRegE  out  1.
- EU_RsE, EU_RtE  out  5  to hazard unit.
- EU_StallE  out  1  stall request; hazard unit freezes F and D while high.

## Operation
- D→E register: zeroed by reset; on edge, holds if EU_StallE=1 (stall beats EU_FlushE), else bubble if EU_FlushE=1, else captures all D inputs.
- SrcA/SrcB: forwarding mux per ForwardAE/BE. EU_WriteDataE = forwarded B. ALU B = ALUSrcE ? SignImmE : forwarded B.
- ALU: add/sub modulo 2^WIDTH, no overflow trap; slt signed, result 1 or 0. Undefined ALUControl codes → 0.
- EU_WriteRegE = RegDstE ? RdE : RtE.
- MFHI/MFLO: EU_AluOutE = HI/LO, ALU bypassed. MULTU/DIVU: EU_RegWriteE and EU_MemWriteE forced 0.
- Engine FSM: IDLE, MUL, DIV. In IDLE with MULTU/DIVU in E and no stall → latch forwarded A, B, count=0, go MUL/DIV. Each busy edge performs one iteration (shift-add; restoring divide); on the 32nd iteration write HI/LO, return IDLE.
- MULTU: {HI,LO} = A*B unsigned, 64-bit. DIVU: LO = A/B, HI = A%B. B=0: LO = all ones, HI = A.
- busy = state≠IDLE. EU_StallE = busy && EU_MDOpE≠000 (combinational). While stalled, EU_RegWriteE, EU_MemWriteE forced 0 so M receives bubbles.
- Reset mid-operation: FSM → IDLE, count, HI, LO → 0; no partial result retained.

## Timing
- All outputs 0 after reset (D→E register zero, ALU and-of-zero, busy 0).
- ALU result available same cycle the instruction occupies E; one-cycle latency from D inputs.
- MULTU/DIVU in E at cycle 0: engine loads at edge 1, busy cycles 1–32, HI/LO updated at edge 33, idle from cycle 33.
- Dependent MD op entering E during cycles 1–32 stalls; proceeds in cycle 33 with new HI/LO.
- Non-MD instructions flow without stall while engine runs.

## Configuration
- EXECUTE_MULDIV_EN defined: engine, HI/LO and stall logic present as above.
- Undefined: no engine or HI/LO; EU_StallE tied 0; MULTU/DIVU behave as nops; MFHI/MFLO return 0 with RegWrite passed through.

## Test plan
- Reset low mid-run → all outputs 0, EU_StallE 0; release, add 5+7 (ALUSrc 0) → EU_AluOutE=12 next cycle.
- ForwardAE=10 with EU_AluOutM=0x100, RD1D=1, sub with B=0x10 → EU_AluOutE=0xF0; slt −1 vs 1 → 1; add 0xFFFFFFFF+1 → 0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF, then MFHI/MFLO → stall 32 cycles; HI=0xFFFFFFFE, LO=0x00000001.
- DIVU 100/7 then MFLO, MFHI → LO=14, HI=2; DIVU 9/0 → LO=0xFFFFFFFF, HI=9.
- EU_FlushE with EU_StallE high → register holds stalled MFHI; FlushE while idle → outputs 0 next cycle.
- Reset during busy cycle 10 → EU_StallE 0 immediately, MFHI afterwards returns 0.
